regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: shares the register bank's single write path between ALU (A) and load (B) results.
// Build option WB_RR_EN: round-robin priority between A and B; when undefined, B always wins a conflict.
module regfile_wb_arbiter #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            A_VALID,
    input  logic [2:0]      A_ADDR,
    input  logic [DW-1:0]   A_DATA,
    output logic            A_READY,
    input  logic            B_VALID,
    input  logic [2:0]      B_ADDR,
    input  logic [DW-1:0]   B_DATA,
    output logic            B_READY,
    output logic [NREG-1:0] WE_OUT,
    output logic [DW-1:0]   D_OUT,
    output logic [NREG-1:0] PEND,
    output logic [15:0]     CONFLICT_CNT
);

    logic            b_wins;
    logic            accept;
    logic [2:0]      sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] sel_mask;
    logic [NREG-1:0] wr_q;

`ifdef WB_RR_EN
    logic prio;  // 0 favours A, 1 favours B; points away from the last winner

    assign b_wins = prio;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio <= 1'b0;
        end else if (A_READY) begin
            prio <= 1'b1;
        end else if (B_READY) begin
            prio <= 1'b0;
        end
    end
`else
    assign b_wins = 1'b1;
`endif

    // READY looks only at the valids and the priority, never at address or data.
    always_comb begin
        A_READY = A_VALID && !(B_VALID && b_wins);
        B_READY = B_VALID && !(A_VALID && !b_wins);
    end

    always_comb begin
        accept   = A_READY || B_READY;
        sel_addr = B_READY ? B_ADDR : A_ADDR;
        sel_data = B_READY ? B_DATA : A_DATA;
        // Register 0 is hardwired to zero, so its strobe is never raised.
        sel_mask = (NREG'(1) << sel_addr) & ~NREG'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_q         <= '0;
            D_OUT        <= '0;
            CONFLICT_CNT <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                wr_q  <= sel_mask;
                D_OUT <= sel_data;
            end else begin
                wr_q  <= '0;
            end
            if (A_VALID && B_VALID && (CONFLICT_CNT != 16'hFFFF)) begin
                CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
            end
        end
    end

    assign WE_OUT = wr_q;
    assign PEND   = wr_q;

endmodule
